// File: rtl/mtx_resp_pkg.sv
// Shared widths, defaults and grant encoding for the matrix-port local-RAM responder.
package mtx_resp_pkg;

  localparam int MTX_ADDR_W     = 10;
  localparam int MTX_DATA_W     = 32;
  localparam int MTX_RAM_DEPTH  = 1 << MTX_ADDR_W;
  localparam int MTX_STARVE_DEF = 7;

  // Which port owns the RAM access issued in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_MTX    = 2'd1,
    GNT_GPU_RD = 2'd2,
    GNT_GPU_WR = 2'd3
  } grant_t;

endpackage

// File: rtl/mtx_lram.sv
// 1024 x 32 synchronous single-port RAM with one-cycle registered read.
module mtx_lram
  import mtx_resp_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [MTX_ADDR_W-1:0] addr,
  input  logic [MTX_DATA_W-1:0] wdata,
  output logic [MTX_DATA_W-1:0] rdata
);

  logic [MTX_DATA_W-1:0] mem [MTX_RAM_DEPTH];

  // rdata keeps its previous value across a write so the port stays no-change.
  always_ff @(posedge sys_clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/gpu_mtx_resp.sv
// Matrix-sequencer / GPU load-store arbiter in front of the shared local RAM.
// Optional matrix anti-starvation counter enabled by defining MTX_RESP_STARVE_EN.
module gpu_mtx_resp
  import mtx_resp_pkg::*;
#(
  parameter int STARVE_MAX = MTX_STARVE_DEF
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  mtx_mreq,
  input  logic [MTX_ADDR_W-1:0] mtxaddr,
  input  logic                  mtx_atomic,
  output logic [MTX_DATA_W-1:0] mtx_data,
  output logic                  datack,
  input  logic                  gpu_mreq,
  input  logic                  gpu_we,
  input  logic [MTX_ADDR_W-1:0] gpu_addr,
  input  logic [MTX_DATA_W-1:0] gpu_wdata,
  output logic                  gpu_ack,
  output logic [MTX_DATA_W-1:0] gpu_rdata
);

  grant_t                grant_next;
  grant_t                grant_reg;
  logic                  mtx_win;
  logic                  starve_force;
  logic                  ram_en;
  logic                  ram_we;
  logic                  ram_we_next;
  logic [MTX_ADDR_W-1:0] ram_addr;
  logic [MTX_DATA_W-1:0] ram_rdata;
  logic [MTX_DATA_W-1:0] mtx_data_reg;
  logic [MTX_DATA_W-1:0] gpu_rdata_reg;

`ifdef MTX_RESP_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;

  assign starve_force = (starve_cnt_reg == STARVE_LIM);

  // Counts consecutive denied matrix requests; any grant or idle cycle clears it.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (mtx_mreq && !mtx_win) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  logic starve_unused;
  assign starve_unused = (STARVE_MAX != 0);
  assign starve_force  = 1'b0;
`endif

  always_comb begin
    mtx_win     = mtx_mreq & (mtx_atomic | starve_force | ~gpu_mreq);
    grant_next  = GNT_NONE;
    ram_addr    = gpu_addr;
    ram_we_next = 1'b0;
    if (mtx_win) begin
      grant_next = GNT_MTX;
      ram_addr   = mtxaddr;
    end else if (gpu_mreq) begin
      grant_next  = gpu_we ? GNT_GPU_WR : GNT_GPU_RD;
      ram_we_next = gpu_we;
    end
  end

  // Reset blocks the RAM access outright so a write issued alongside reset is dropped.
  assign ram_en = (grant_next != GNT_NONE) & ~reset;
  assign ram_we = ram_we_next & ~reset;

  mtx_lram u_lram (
    .sys_clk (sys_clk),
    .en      (ram_en),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (gpu_wdata),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      grant_reg     <= GNT_NONE;
      mtx_data_reg  <= '0;
      gpu_rdata_reg <= '0;
    end else begin
      grant_reg <= grant_next;
      if (grant_reg == GNT_MTX) begin
        mtx_data_reg <= ram_rdata;
      end
      if (grant_reg == GNT_GPU_RD) begin
        gpu_rdata_reg <= ram_rdata;
      end
    end
  end

  // Live RAM data during the ack cycle, captured copy afterwards.
  assign datack    = (grant_reg == GNT_MTX);
  assign gpu_ack   = (grant_reg == GNT_GPU_RD) | (grant_reg == GNT_GPU_WR);
  assign mtx_data  = datack ? ram_rdata : mtx_data_reg;
  assign gpu_rdata = (grant_reg == GNT_GPU_RD) ? ram_rdata : gpu_rdata_reg;

endmodule

// File: tb/tb_gpu_mtx_resp.sv
// Scoreboard bench for gpu_mtx_resp: directed scenarios plus random traffic vs. a behavioural model.
module tb_gpu_mtx_resp;

  localparam int TB_STARVE = 3;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        mtx_mreq;
  logic [9:0]  mtxaddr;
  logic        mtx_atomic;
  logic [31:0] mtx_data;
  logic        datack;
  logic        gpu_mreq;
  logic        gpu_we;
  logic [9:0]  gpu_addr;
  logic [31:0] gpu_wdata;
  logic        gpu_ack;
  logic [31:0] gpu_rdata;

  gpu_mtx_resp #(.STARVE_MAX(TB_STARVE)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .mtx_mreq   (mtx_mreq),
    .mtxaddr    (mtxaddr),
    .mtx_atomic (mtx_atomic),
    .mtx_data   (mtx_data),
    .datack     (datack),
    .gpu_mreq   (gpu_mreq),
    .gpu_we     (gpu_we),
    .gpu_addr   (gpu_addr),
    .gpu_wdata  (gpu_wdata),
    .gpu_ack    (gpu_ack),
    .gpu_rdata  (gpu_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          datack;
    logic [31:0] mdata;
    bit          gack;
    logic [31:0] gdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_m [1024];
  logic [31:0] last_mtx;
  logic [31:0] last_gpu;
  int          starve_m;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: one RAM owner per cycle, loser simply dropped, response one cycle later.
  task automatic apply(input bit mreq, input logic [9:0] maddr, input bit atomic,
                       input bit greq, input bit gwe, input logic [9:0] gaddr,
                       input logic [31:0] gwd);
    exp_t e;
    bit   forced;
    bit   mtx_gets_ram;
    mtx_mreq   = mreq;
    mtxaddr    = maddr;
    mtx_atomic = atomic;
    gpu_mreq   = greq;
    gpu_we     = gwe;
    gpu_addr   = gaddr;
    gpu_wdata  = gwd;
    forced = 1'b0;
`ifdef MTX_RESP_STARVE_EN
    forced = (starve_m == TB_STARVE);
`endif
    if (!mreq)             mtx_gets_ram = 1'b0;
    else if (atomic)       mtx_gets_ram = 1'b1;
    else if (forced)       mtx_gets_ram = 1'b1;
    else                   mtx_gets_ram = !greq;
    e.datack = 1'b0;
    e.gack   = 1'b0;
    if (mtx_gets_ram) begin
      e.datack = 1'b1;
      last_mtx = mem_m[maddr];
    end else if (greq) begin
      e.gack = 1'b1;
      if (gwe) mem_m[gaddr] = gwd;
      else     last_gpu = mem_m[gaddr];
    end
    if (mreq && !mtx_gets_ram) starve_m++;
    else                       starve_m = 0;
    e.mdata = last_mtx;
    e.gdata = last_gpu;
    sb_q.push_back(e);
  endtask

  task automatic issue(input bit mreq, input logic [9:0] maddr, input bit atomic,
                       input bit greq, input bit gwe, input logic [9:0] gaddr,
                       input logic [31:0] gwd);
    @(negedge sys_clk);
    apply(mreq, maddr, atomic, greq, gwe, gaddr, gwd);
  endtask

  // Reset pulse landing on a granted GPU write; the write must not reach the RAM.
  task automatic reset_mid_write(input logic [9:0] gaddr, input logic [31:0] gwd);
    @(negedge sys_clk);
    mtx_mreq   = 1'b0;
    mtx_atomic = 1'b0;
    gpu_mreq   = 1'b1;
    gpu_we     = 1'b1;
    gpu_addr   = gaddr;
    gpu_wdata  = gwd;
    reset      = 1'b1;
    #1;
    chk("rst_async_datack", 32'(datack), 32'd0);
    chk("rst_async_gpu_ack", 32'(gpu_ack), 32'd0);
    @(posedge sys_clk);
    #1;
    chk("rst_datack", 32'(datack), 32'd0);
    chk("rst_gpu_ack", 32'(gpu_ack), 32'd0);
    chk("rst_mtx_data", mtx_data, 32'd0);
    chk("rst_gpu_rdata", gpu_rdata, 32'd0);
    last_mtx = 32'd0;
    last_gpu = 32'd0;
    starve_m = 0;
    @(negedge sys_clk);
    reset = 1'b0;
    apply(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  // Monitor: one expected response per clock once traffic has been issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("datack", 32'(datack), 32'(e.datack));
        chk("gpu_ack", 32'(gpu_ack), 32'(e.gack));
        chk("mtx_data", mtx_data, e.mdata);
        chk("gpu_rdata", gpu_rdata, e.gdata);
        if (datack || gpu_ack)
          $display("t=%0t datack=%0b mtx_data=%h gpu_ack=%0b gpu_rdata=%h",
                   $time, datack, mtx_data, gpu_ack, gpu_rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    mtx_mreq   = 1'b0;
    mtxaddr    = '0;
    mtx_atomic = 1'b0;
    gpu_mreq   = 1'b0;
    gpu_we     = 1'b0;
    gpu_addr   = '0;
    gpu_wdata  = '0;
    last_mtx   = 32'd0;
    last_gpu   = 32'd0;
    starve_m   = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_datack", 32'(datack), 32'd0);
    chk("reset_gpu_ack", 32'(gpu_ack), 32'd0);
    chk("reset_mtx_data", mtx_data, 32'd0);
    chk("reset_gpu_rdata", gpu_rdata, 32'd0);
    @(negedge sys_clk);
    reset = 1'b0;
    apply(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);

    // Fill the whole RAM through the GPU port so every later read has a known value.
    for (int i = 0; i < 1024; i++) begin
      issue(1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 10'(i),
            (i == 'h010) ? 32'h1234_5678 : $urandom);
    end

    issue(1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    for (int i = 0; i < 4; i++) issue(1'b1, 10'(32'h020 + i), 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    issue(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);

    issue(1'b1, 10'h031, 1'b0, 1'b1, 1'b0, 10'h030, 32'd0);
    issue(1'b1, 10'h031, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);

    issue(1'b1, 10'h032, 1'b1, 1'b1, 1'b0, 10'h033, 32'd0);
    issue(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'h033, 32'd0);

    issue(1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 10'h040, 32'hDEAD_BEEF);
    issue(1'b1, 10'h040, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);

    issue(1'b1, 10'h041, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    reset_mid_write(10'h050, 32'hBAD0_BAD0);
    issue(1'b1, 10'h050, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    issue(1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'h050, 32'd0);

    // Matrix held against continuous GPU traffic, non-atomic.
    for (int i = 0; i < 8; i++) issue(1'b1, 10'h060, 1'b0, 1'b1, 1'b0, 10'(32'h070 + i), 32'd0);
    issue(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);

    for (int i = 0; i < 600; i++) begin
      issue(1'($urandom_range(0, 1)), 10'($urandom), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom), $urandom);
    end
    issue(1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);

    repeat (3) @(posedge sys_clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
